mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequencing controller that computes an OP_W x OP_W unsigned product by time-multiplexing one 4x4 combinational array multiplier.
- Splits operands into 4-bit nibbles and issues one nibble pair per cycle.
- Accumulates the shifted partial products into a 2*OP_W result.
- Sits between a valid/ready producer and consumer; gives wide multiplies without a wide array.

Parameters:
- OP_W, 8, operand width in bits; must be a multiple of 4, minimum 4. N = OP_W/4 nibbles; one product takes N*N steps.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- a  input  OP_W  multiplicand
- b  input  OP_W  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- p  output  2*OP_W  product
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset values: in_ready=1, out_valid=0, p=0, busy=0. Internal state: IDLE, step counter=0, accumulator=0.
- Reset is synchronous; when sampled high it overrides everything, including mid-CALC. The in-flight product is discarded and no out_valid is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a and b, clear the accumulator, set cnt=0, go to CALC.
- CALC:
  - in_ready=0. The handshake is ignored.
  - Each cycle: ai = cnt mod N, bj = cnt div N. pp = a[4*ai+:4] * b[4*bj+:4], 8 bits, from the 4x4 multiplier.
  - Accumulator += pp << 4*(ai+bj). The accumulator is 2*OP_W bits; the sum never exceeds 2*OP_W bits, so no overflow is possible.
  - cnt increments each cycle. When cnt == N*N-1, the final add occurs and the FSM goes to DONE.
- DONE:
  - out_valid=1; p = accumulator, held stable.
  - On out_valid&out_ready, go to IDLE, and out_valid drops the next cycle.
  - in_ready stays 0 in DONE; there is no same-cycle pass-through.
- Latency:
  - The accept edge is cycle 0. CALC occupies cycles 1..N*N; out_valid is first high in cycle N*N+1. For OP_W=8 that is 4 CALC cycles, out_valid in cycle 5.
  - Minimum spacing between accepts is N*N+2 cycles.
- Backpressure: out_ready low holds DONE indefinitely, with p unchanged and in_ready=0.
- Operand inputs a and b are don't-care outside the accept cycle; only the latched copies are used.
- p is driven from the accumulator register only (registered output). p is don't-care when out_valid=0, except that it is 0 after reset.

Optional Feature:
- Macro: MULT_SEQ_ZERO_SKIP_EN.
- Defined:
  - On accept, if a==0 or b==0, skip CALC and go directly to DONE with accumulator=0.
  - out_valid is then high in cycle 1.
- Undefined: every operand pair takes the full N*N CALC cycles regardless of value.

Decomposition:
- Shared package (mult_pkg):
  - FSM state enum {IDLE, CALC, DONE}.
  - NIB_W=4 constant.
  - Function computing N from OP_W.
- Sub-module: one instance of the existing 4x4 array multiplier mult4bit. Its inputs are driven by nibble muxes; the controller contains no multiplier logic itself.

Test Plan:
- OP_W=8; reset, then a=0x12, b=0x34, out_ready=1 -> in_ready drops cycle 1; out_valid high cycle 5 with p=0x03A8 for exactly one cycle; in_ready=1 cycle 6.
- a=0xFF, b=0xFF -> p=0xFE01.
- a=0x80, b=0x02 -> p=0x0100 (shift placement check).
- a=0x9C, b=0x47, out_ready held low 6 cycles after out_valid -> p=0x2B44 stable throughout, in_ready=0, second in_valid not accepted; out_ready=1 -> out_valid drops next cycle.
- Assert rst in cycle 2 of CALC -> next cycle in_ready=1, out_valid=0, p=0, busy=0. Then a=0x03, b=0x05 -> p=0x000F.
- a=0x00, b=0xAB:
  - macro defined -> out_valid in cycle 1, p=0x0000.
  - undefined -> out_valid in cycle 5, p=0x0000.
- Back-to-back in_valid with 200 random pairs, out_ready random -> every p matches the a*b reference model, and accepts are spaced at least 6 cycles apart.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential nibble multiplier.
//   state_t    : controller FSM states (IDLE, CALC, DONE)
//   NIB_W      : width of one operand slice fed to the 4x4 array multiplier
//   nib_count  : number of nibbles in an operand of a given width
package mult_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int op_w);
    return op_w / NIB_W;
  endfunction

endpackage

// File: rtl/mult4bit.sv
// mult4bit: combinational 4x4 unsigned array multiplier (shift-and-add rows).
// Ports:
//   i_a, i_b : NIB_W-bit unsigned operands
//   o_p      : 2*NIB_W-bit unsigned product
module mult4bit
  import mult_pkg::*;
(
  input  logic [NIB_W-1:0]   i_a,
  input  logic [NIB_W-1:0]   i_b,
  output logic [2*NIB_W-1:0] o_p
);

  always_comb begin
    o_p = '0;
    for (int i = 0; i < NIB_W; i++) begin
      if (i_b[i]) begin
        o_p = o_p + ((2*NIB_W)'(i_a) << i);
      end
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: OP_W x OP_W unsigned multiplier built from one 4x4 array
// multiplier, issuing one nibble pair per cycle and accumulating the shifted
// partial products.
//
// State table:
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand pair
//   CALC  | one nibble pair per cycle, N*N cycles
//   DONE  | out_valid high, p held until out_ready
//
// Parameters:
//   OP_W : operand width, multiple of 4, minimum 4
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b latched on accept)
//   out_valid/out_ready : product handshake (p valid while out_valid)
//   p                   : 2*OP_W-bit product, straight from the accumulator
//   busy                : high in CALC or DONE
// Build option:
//   MULT_SEQ_ZERO_SKIP_EN : a zero operand skips CALC and goes straight to DONE
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] p,
  output logic              busy
);

  localparam int N     = nib_count(OP_W);
  localparam int STEPS = N * N;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SH_W  = $clog2(2 * OP_W);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*OP_W-1:0]   r_acc;

  logic [IDX_W-1:0]    w_ai;
  logic [IDX_W-1:0]    w_bj;
  logic [NIB_W-1:0]    w_nib_a;
  logic [NIB_W-1:0]    w_nib_b;
  logic [2*NIB_W-1:0]  w_pp;
  logic [SH_W-1:0]     w_shift;
  logic [2*OP_W-1:0]   w_pp_sh;
  logic                w_last;
  logic                w_accept;
  logic                w_skip;

  // cnt walks a-nibbles fastest: cnt = bj*N + ai
  assign w_ai    = IDX_W'(r_cnt % N);
  assign w_bj    = IDX_W'(r_cnt / N);
  assign w_nib_a = r_a[NIB_W*w_ai +: NIB_W];
  assign w_nib_b = r_b[NIB_W*w_bj +: NIB_W];
  assign w_shift = SH_W'((int'(w_ai) + int'(w_bj)) * NIB_W);
  assign w_pp_sh = (2*OP_W)'(w_pp) << w_shift;
  assign w_last  = (r_cnt == CNT_W'(STEPS - 1));

  mult4bit u_mult4bit (
    .i_a (w_nib_a),
    .i_b (w_nib_b),
    .o_p (w_pp)
  );

`ifdef MULT_SEQ_ZERO_SKIP_EN
  assign w_skip = (a == '0) || (b == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_accept = in_valid && in_ready;
  assign p        = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_skip ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_cnt <= '0;
            r_acc <= '0;
          end
        end
        CALC: begin
          // Partial sums never exceed a*b, so 2*OP_W bits cannot overflow.
          r_acc <= r_acc + w_pp_sh;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

  localparam int OP_W  = 8;
  localparam int STEPS = (OP_W / 4) * (OP_W / 4);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [2*OP_W-1:0] p;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  mult_seq_ctrl #(.OP_W(OP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycles from the accept edge until out_valid is first seen.
  function automatic int exp_lat(input logic [OP_W-1:0] ta, input logic [OP_W-1:0] tb);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    if (ta == 0 || tb == 0) return 1;
`endif
    return STEPS + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [OP_W-1:0] ta, input logic [OP_W-1:0] tb, input int stall);
    logic [2*OP_W-1:0] exp_p;
    int lat;
    exp_p = (2*OP_W)'(ta) * (2*OP_W)'(tb);
    chk("idle_ready", in_ready, 1);
    a = ta; b = tb; in_valid = 1'b1; out_ready = (stall == 0);
    tick();
    in_valid = 1'b0; a = OP_W'($urandom); b = OP_W'($urandom);
    lat = 1;
    chk("ready_drop", in_ready, 0);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat(ta, tb));
    chk("product", p, exp_p);
    chk("done_busy", busy, 1);
    chk("done_ready", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = OP_W'($urandom); b = OP_W'($urandom);
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_p", p, exp_p);
      chk("stall_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*OP_W-1:0] q[$];
    logic [OP_W-1:0]   last_a, last_b, ra, rb;
    int cyc, last_acc, n_acc, due;
    bit waiting;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_busy", busy, 0);

    run_op(8'h12, 8'h34, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h80, 8'h02, 0);
    run_op(8'h9C, 8'h47, 6);

    // reset during CALC discards the product
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("calc_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_p", p, 0);
    chk("mid_rst_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_valid", out_valid, 0);
    end
    run_op(8'h03, 8'h05, 0);
    run_op(8'h00, 8'hAB, 0);
    run_op(8'h5A, 8'h00, 2);

    // random back-to-back traffic against an a*b scoreboard
    cyc = 0; last_acc = 0; n_acc = 0; due = 0; waiting = 1'b0;
    last_a = '0; last_b = '0;
    while ((n_acc < 200 || q.size() > 0) && cyc < 20000) begin
      ra = OP_W'($urandom); rb = OP_W'($urandom);
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      in_valid  = (n_acc < 200);
      a = ra; b = rb;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid) begin
        chk("rand_spurious", (q.size() > 0), 1);
        if (waiting) begin
          chk("rand_lat", cyc, due);
          waiting = 1'b0;
        end
        if (out_ready && q.size() > 0) chk("rand_p", p, q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (n_acc > 0) chk("accept_gap", ((cyc - last_acc) >= exp_lat(last_a, last_b) + 1), 1);
        q.push_back((2*OP_W)'(ra) * (2*OP_W)'(rb));
        last_acc = cyc; last_a = ra; last_b = rb;
        due = cyc + exp_lat(ra, rb);
        waiting = 1'b1;
        n_acc++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_accepts", n_acc, 200);
    chk("rand_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
